// File: rtl/freq_opt_pkg.sv
// rtl/freq_opt_pkg.sv - shared widths, FSM state encoding and ADC word type for freq_optimizer
package freq_opt_pkg;

    localparam int ADC_W_DEF = 12;
    localparam int CNT_W_DEF = 12;

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        MEASURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    typedef logic [ADC_W_DEF-1:0] adc_word_t;

endpackage

// File: rtl/freq_optimizer_sample_counter.sv
// rtl/freq_optimizer_sample_counter.sv - free-running sample counter that paces ADC measurements
//
// Ports:
//   clk        in   1      clock, posedge
//   nrst       in   1      asynchronous reset, active-high
//   value      out  CNT_W  current counter value, wraps 2^CNT_W-1 -> 0
//   sample_evt out  1      combinational, high while value == SAMPLE_AT
module sample_counter
    import freq_opt_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int SAMPLE_AT = (1 << CNT_W_DEF) - 1
) (
    input  logic             clk,
    input  logic             nrst,
    output logic [CNT_W-1:0] value,
    output logic             sample_evt
);

    logic [CNT_W-1:0] value_q;
    logic [CNT_W-1:0] value_d;

    // Natural binary wrap gives the 2^CNT_W-cycle settling window.
    always_comb begin
        value_d = value_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value      = value_q;
    assign sample_evt = (value_q == CNT_W'(SAMPLE_AT));

endmodule

// File: rtl/freq_optimizer.sv
// rtl/freq_optimizer.sv - hill-climbing resonant-frequency tracker issuing up/down step requests
//
// Optional feature macro: FREQ_RESTART_EN (re-search when ADC drifts DRIFT LSB below locked value).
//
// Ports:
//   clk               in   1      clock, posedge
//   nrst              in   1      asynchronous reset, active-high
//   ADC_in            in   ADC_W  unsigned ADC word, sampled only on a sample event
//   value             out  CNT_W  sample-counter value
//   freq_ready        out  1      one-cycle step request, the cycle after a sample event
//   freq_set_up_down  out  1      step direction, 1 = raise, held between pulses
//   freq_opt          out  1      optimum reached
module freq_optimizer
    import freq_opt_pkg::*;
#(
    parameter int ADC_W     = ADC_W_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int SAMPLE_AT = (1 << CNT_W_DEF) - 1,
    parameter int HYST      = 2,
`ifdef FREQ_RESTART_EN
    parameter int DRIFT     = 32,
`endif
    parameter int REV_LIMIT = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [ADC_W-1:0] ADC_in,
    output logic [CNT_W-1:0] value,
    output logic             freq_ready,
    output logic             freq_set_up_down,
    output logic             freq_opt
);

    localparam int REV_W = $clog2(REV_LIMIT + 1);

    logic sample_evt;

    sample_counter #(
        .CNT_W     (CNT_W),
        .SAMPLE_AT (SAMPLE_AT)
    ) u_sample_counter (
        .clk        (clk),
        .nrst       (nrst),
        .value      (value),
        .sample_evt (sample_evt)
    );

    state_t             state_q, state_d;
    logic [ADC_W-1:0]   prev_q, prev_d;
    logic [REV_W-1:0]   rev_cnt_q, rev_cnt_d;
    logic               ready_q, ready_d;
    logic               dir_q, dir_d;
    logic               opt_q, opt_d;
`ifdef FREQ_RESTART_EN
    logic [ADC_W-1:0]   lock_q, lock_d;
`endif

    // One extra bit keeps prev+HYST and cur+DRIFT from wrapping.
    logic [ADC_W:0]     cur_ext;
    logic [ADC_W:0]     prev_ext;
    logic               improved;
    logic [REV_W-1:0]   rev_next;

    always_comb begin
        cur_ext  = {1'b0, ADC_in};
        prev_ext = {1'b0, prev_q};
        improved = cur_ext > (prev_ext + (ADC_W+1)'(HYST));
        rev_next = rev_cnt_q + REV_W'(1);

        state_d   = state_q;
        prev_d    = prev_q;
        rev_cnt_d = rev_cnt_q;
        ready_d   = 1'b0;
        dir_d     = dir_q;
        opt_d     = opt_q;
`ifdef FREQ_RESTART_EN
        lock_d    = lock_q;
`endif

        case (state_q)
            INIT: begin
                if (sample_evt) begin
                    prev_d  = ADC_in;
                    dir_d   = 1'b1;
                    ready_d = 1'b1;
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (sample_evt) begin
                    prev_d = ADC_in;
                    if (improved) begin
                        ready_d = 1'b1;
                    end else begin
                        // A drop or a flat reading both count as passing the peak.
                        rev_cnt_d = rev_next;
                        if (rev_next == REV_W'(REV_LIMIT)) begin
                            state_d = DONE;
                            opt_d   = 1'b1;
`ifdef FREQ_RESTART_EN
                            lock_d  = prev_q;
`endif
                        end else begin
                            dir_d   = ~dir_q;
                            ready_d = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
`ifdef FREQ_RESTART_EN
                if (sample_evt &&
                    ((cur_ext + (ADC_W+1)'(DRIFT)) < {1'b0, lock_q})) begin
                    opt_d     = 1'b0;
                    rev_cnt_d = '0;
                    prev_d    = ADC_in;
                    ready_d   = 1'b1;
                    state_d   = MEASURE;
                end
`else
                // Absorbing: only reset leaves the locked state.
                state_d = DONE;
`endif
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state_q   <= INIT;
            prev_q    <= '0;
            rev_cnt_q <= '0;
            ready_q   <= 1'b0;
            dir_q     <= 1'b1;
            opt_q     <= 1'b0;
`ifdef FREQ_RESTART_EN
            lock_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            rev_cnt_q <= rev_cnt_d;
            ready_q   <= ready_d;
            dir_q     <= dir_d;
            opt_q     <= opt_d;
`ifdef FREQ_RESTART_EN
            lock_q    <= lock_d;
`endif
        end
    end

    assign freq_ready       = ready_q;
    assign freq_set_up_down = dir_q;
    assign freq_opt         = opt_q;

endmodule

// File: tb/tb_freq_optimizer.sv
// tb/tb_freq_optimizer.sv - scoreboard bench for freq_optimizer with randomized ADC stimulus
module tb_freq_optimizer;

    localparam int ADC_W     = 12;
    localparam int CNT_W     = 7;
    localparam int SAMPLE_AT = (1 << CNT_W) - 1;
    localparam int HYST      = 2;
    localparam int REV_LIMIT = 4;
`ifdef FREQ_RESTART_EN
    localparam int DRIFT     = 32;
`endif

    logic             clk = 1'b0;
    logic             nrst = 1'b1;
    logic [ADC_W-1:0] ADC_in = '0;
    logic [CNT_W-1:0] value;
    logic             freq_ready;
    logic             freq_set_up_down;
    logic             freq_opt;

    freq_optimizer #(
        .ADC_W     (ADC_W),
        .CNT_W     (CNT_W),
        .SAMPLE_AT (SAMPLE_AT),
        .HYST      (HYST),
        .REV_LIMIT (REV_LIMIT)
    ) dut (
        .clk              (clk),
        .nrst             (nrst),
        .ADC_in           (ADC_in),
        .value            (value),
        .freq_ready       (freq_ready),
        .freq_set_up_down (freq_set_up_down),
        .freq_opt         (freq_opt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int ready;
        int dir;
        int opt;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference counter: where the sample events fall, derived from reset release alone.
    int ref_cnt      = 0;
    bit ref_evt_prev = 1'b0;

    always @(posedge clk or posedge nrst) begin
        if (nrst) begin
            ref_cnt      <= 0;
            ref_evt_prev <= 1'b0;
        end else begin
            ref_evt_prev <= (ref_cnt == SAMPLE_AT);
            ref_cnt      <= (ref_cnt + 1) % (1 << CNT_W);
        end
    end

    // Monitor: every output slot after a sample event pops one expectation.
    int exp_dir = 1;
    int exp_opt = 0;

    always @(negedge clk) begin
        exp_t e;
        if (nrst) begin
            exp_q.delete();
            exp_dir = 1;
            exp_opt = 0;
            check("rst_value", int'(value), 0);
            check("rst_ready", int'(freq_ready), 0);
            check("rst_dir", int'(freq_set_up_down), 1);
            check("rst_opt", int'(freq_opt), 0);
        end else begin
            check("value", int'(value), ref_cnt);
            if (ref_evt_prev) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("evt_ready", int'(freq_ready), e.ready);
                    check("evt_dir", int'(freq_set_up_down), e.dir);
                    check("evt_opt", int'(freq_opt), e.opt);
                    exp_dir = e.dir;
                    exp_opt = e.opt;
                end
            end else begin
                check("idle_ready", int'(freq_ready), 0);
                check("hold_dir", int'(freq_set_up_down), exp_dir);
                check("hold_opt", int'(freq_opt), exp_opt);
            end
            check("ready_opt_excl", int'(freq_ready & freq_opt), 0);
        end
    end

    // Behavioural tracker model: phase 0 = waiting first sample, 1 = searching, 2 = locked.
    int m_phase = 0;
    int m_prev  = 0;
    int m_dir   = 1;
    int m_revs  = 0;
    int m_lock  = 0;

    task automatic model_event(input int s);
        exp_t e;
        e.ready = 0;
        e.dir   = m_dir;
        e.opt   = 0;
        if (m_phase == 0) begin
            m_dir   = 1;
            m_phase = 1;
            m_prev  = s;
            e.ready = 1;
        end else if (m_phase == 1) begin
            if (s > m_prev + HYST) begin
                e.ready = 1;
            end else begin
                m_revs++;
                if (m_revs == REV_LIMIT) begin
                    m_phase = 2;
                    m_lock  = m_prev;
                    e.opt   = 1;
                end else begin
                    m_dir   = 1 - m_dir;
                    e.ready = 1;
                end
            end
            m_prev = s;
        end else begin
            e.opt = 1;
`ifdef FREQ_RESTART_EN
            if (s + DRIFT < m_lock) begin
                m_phase = 1;
                m_revs  = 0;
                m_prev  = s;
                e.opt   = 0;
                e.ready = 1;
            end
`endif
        end
        e.dir = m_dir;
        exp_q.push_back(e);
    endtask

    // Drive noise until the event cycle, then present the sample for that event.
    task automatic do_event(input int s);
        @(negedge clk);
        while (ref_cnt != SAMPLE_AT) begin
            ADC_in = ADC_W'($urandom);
            @(negedge clk);
        end
        ADC_in = ADC_W'(s);
        model_event(s);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        #2;
        nrst = 1'b1;
        #1;
        check("async_rst_value", int'(value), 0);
        check("async_rst_ready", int'(freq_ready), 0);
        check("async_rst_dir", int'(freq_set_up_down), 1);
        check("async_rst_opt", int'(freq_opt), 0);
        repeat (cycles) @(negedge clk);
        #2;
        nrst    = 1'b0;
        m_phase = 0;
        m_prev  = 0;
        m_dir   = 1;
        m_revs  = 0;
        m_lock  = 0;
    endtask

    task automatic run_list(input int vals[$]);
        foreach (vals[i]) do_event(vals[i]);
    endtask

    initial begin
        int s;
        int r;
        repeat (5) @(negedge clk);
        #2;
        nrst = 1'b0;

        run_list('{100, 200, 150, 151, 140, 130, 300, 90, 95});

        do_reset(3);
        run_list('{100, 200, 150, 160, 140, 130, 120, 110, 115});

        do_reset(2);
        run_list('{100, 200, 150});
        repeat (40) @(negedge clk);
        do_reset(4);
        run_list('{300, 310, 320});

        do_reset(2);
        run_list('{400, 500, 500, 500, 500, 500, 480, 460, 470, 480, 470, 440});

        do_reset(2);
        run_list('{4095, 4095, 0, 4094, 4095, 4095, 0});

        for (int ep = 0; ep < 6; ep++) begin
            do_reset(1 + ep);
            for (int k = 0; k < 25; k++) begin
                r = $urandom_range(0, 2);
                if (r == 0) begin
                    s = m_prev + $urandom_range(0, HYST + 1);
                end else if (r == 1) begin
                    s = m_prev + $urandom_range(0, 80) - 40;
                end else begin
                    s = $urandom_range(0, (1 << ADC_W) - 1);
                end
                if (s < 0) s = 0;
                if (s > (1 << ADC_W) - 1) s = (1 << ADC_W) - 1;
                do_event(s);
            end
        end

        repeat (3) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
